// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer/flag controller for the Ethernet async FIFO: synchronizes the
// Gray write pointer, advances the read address and supports snapshot/rewind/commit replay.
module fifo_rd_ptr_ctrl #(
  parameter int ADDR_WIDTH        = 8,
  parameter int ALMOST_EMPTY_DIFF = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  read,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   r_ptr,
  input  logic                  latch_addr,
  input  logic                  rewind,
  input  logic                  commit
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_DIFF = PW'(ALMOST_EMPTY_DIFF);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] sync1_reg, sync2_reg;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rd_bin_reg, rd_next;
  logic [PW-1:0] saved_reg, saved_next;
  logic [PW-1:0] level_next, pub_next;
  logic [PW-1:0] rd_level_reg, r_ptr_reg;
  logic          empty_reg, almost_empty_reg;
  logic          rd_en, held, rewind_held;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_g2b
      assign wbin[gi] = ^sync2_reg[PW-1:gi];
    end
  endgenerate

  always_comb begin
    rd_en       = read & ~empty_reg;
    held        = (state_reg == HELD);
    rewind_held = rewind & held;
    rd_next     = rewind_held ? saved_reg : (rd_bin_reg + PW'(rd_en));
    state_next  = state_reg;
    saved_next  = saved_reg;
    // Latch beats commit; a rewind in the same cycle keeps the old snapshot.
    if (latch_addr) begin
      state_next = HELD;
      if (!rewind_held) begin
        saved_next = rd_next;
      end
    end else if (commit && held) begin
      state_next = IDLE;
    end
    level_next = wbin - rd_next;
    pub_next   = (state_next == HELD) ? saved_next : rd_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      sync1_reg        <= '0;
      sync2_reg        <= '0;
      rd_bin_reg       <= '0;
      saved_reg        <= '0;
      rd_level_reg     <= '0;
      r_ptr_reg        <= '0;
      empty_reg        <= 1'b1;
      almost_empty_reg <= 1'b1;
    end else begin
      state_reg        <= state_next;
      sync1_reg        <= wr_ptr;
      sync2_reg        <= sync1_reg;
      rd_bin_reg       <= rd_next;
      saved_reg        <= saved_next;
      rd_level_reg     <= level_next;
      r_ptr_reg        <= (pub_next >> 1) ^ pub_next;
      empty_reg        <= (level_next == '0);
      almost_empty_reg <= (level_next <= AE_DIFF);
    end
  end

  assign r_addr       = rd_bin_reg[ADDR_WIDTH-1:0];
  assign r_ptr        = r_ptr_reg;
  assign rd_level     = rd_level_reg;
  assign empty        = empty_reg;
  assign almost_empty = almost_empty_reg;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed self-checking bench for fifo_rd_ptr_ctrl (ADDR_WIDTH=8, ALMOST_EMPTY_DIFF=4).
module tb_fifo_rd_ptr_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, read, latch_addr, rewind, commit;
  logic       empty, almost_empty;
  logic [8:0] rd_level, wr_ptr, r_ptr;
  logic [7:0] r_addr;

  int checks = 0;
  int errors = 0;

  fifo_rd_ptr_ctrl #(.ADDR_WIDTH(8), .ALMOST_EMPTY_DIFF(4)) dut (
    .clk(clk), .reset_n(reset_n), .read(read), .empty(empty),
    .almost_empty(almost_empty), .rd_level(rd_level), .wr_ptr(wr_ptr),
    .r_addr(r_addr), .r_ptr(r_ptr), .latch_addr(latch_addr),
    .rewind(rewind), .commit(commit)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] gray(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int addr, input int lvl,
                         input int emp, input int ae, input int ptr);
    $display("step %-14s r_addr=%0d rd_level=%0d empty=%0b almost_empty=%0b r_ptr=%0h",
             tag, r_addr, rd_level, empty, almost_empty, r_ptr);
    check({tag, ".r_addr"},       32'(r_addr),       32'(addr));
    check({tag, ".rd_level"},     32'(rd_level),     32'(lvl));
    check({tag, ".empty"},        32'(empty),        32'(emp));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    check({tag, ".r_ptr"},        32'(r_ptr),        32'(ptr));
  endtask

  // Reads n entries starting from binary pointer 'from' (IDLE state, read already high).
  task automatic read_burst(input int from, input int n);
    logic [8:0] prev;
    int v;
    for (int k = 0; k < n; k++) begin
      prev = r_ptr;
      tick();
      v = (from + k + 1) % 512;
      check($sformatf("burst%0d.r_addr", v), 32'(r_addr), 32'(v % 256));
      check($sformatf("burst%0d.r_ptr", v), 32'(r_ptr), 32'(gray(9'(v))));
      check($sformatf("burst%0d.gray_step", v), 32'($countones(prev ^ r_ptr)), 32'(1));
    end
  endtask

  initial begin
    reset_n = 1'b0; read = 1'b0; latch_addr = 1'b0; rewind = 1'b0; commit = 1'b0;
    wr_ptr = '0;
    tick(2);
    chk_all("reset", 0, 0, 1, 1, 0);

    // Write pointer latency: flags move on the third edge.
    reset_n = 1'b1; wr_ptr = gray(9'd3);
    tick(2);
    check("latency.empty", 32'(empty), 32'(1));
    tick();
    chk_all("wr3", 0, 3, 0, 1, 0);

    wr_ptr = gray(9'd10);
    tick(3);
    chk_all("wr10", 0, 10, 0, 0, 0);
    read = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_all($sformatf("read%0d", i), i, 10 - i, int'(i == 10), int'(10 - i <= 4),
              int'(gray(9'(i))));
    end
    tick(3);
    chk_all("read_empty", 10, 0, 1, 1, int'(gray(9'd10)));
    read = 1'b0;

    // Replay sequence around address 20.
    wr_ptr = gray(9'd40);
    tick(3);
    chk_all("wr40", 10, 30, 0, 0, int'(gray(9'd10)));
    read = 1'b1; tick(10); read = 1'b0;
    chk_all("at20", 20, 20, 0, 0, int'(gray(9'd20)));
    latch_addr = 1'b1; tick(); latch_addr = 1'b0;
    chk_all("latch20", 20, 20, 0, 0, int'(gray(9'd20)));
    read = 1'b1; tick(6); read = 1'b0;
    chk_all("held_rd6", 26, 14, 0, 0, int'(gray(9'd20)));
    rewind = 1'b1; tick(); rewind = 1'b0;
    chk_all("rewind", 20, 20, 0, 0, int'(gray(9'd20)));
    read = 1'b1; tick(2);
    chk_all("held_rd2", 22, 18, 0, 0, int'(gray(9'd20)));
    rewind = 1'b1; tick(); rewind = 1'b0; read = 1'b0;
    chk_all("read_rewind", 20, 20, 0, 0, int'(gray(9'd20)));
    commit = 1'b1; tick(); commit = 1'b0;
    chk_all("commit", 20, 20, 0, 0, int'(gray(9'd20)));
    read = 1'b1; tick(); read = 1'b0;
    chk_all("idle_read", 21, 19, 0, 0, int'(gray(9'd21)));

    // Rewind and commit are ignored in IDLE.
    rewind = 1'b1; tick(); rewind = 1'b0;
    chk_all("idle_rewind", 21, 19, 0, 0, int'(gray(9'd21)));
    commit = 1'b1; tick(); commit = 1'b0;
    chk_all("idle_commit", 21, 19, 0, 0, int'(gray(9'd21)));

    latch_addr = 1'b1; commit = 1'b1; tick(); latch_addr = 1'b0; commit = 1'b0;
    chk_all("latch_commit", 21, 19, 0, 0, int'(gray(9'd21)));
    read = 1'b1; tick(2);
    chk_all("held_after_lc", 23, 17, 0, 0, int'(gray(9'd21)));
    latch_addr = 1'b1; tick(); latch_addr = 1'b0;
    chk_all("read_latch", 24, 16, 0, 0, int'(gray(9'd24)));
    tick(2); read = 1'b0;
    chk_all("held_rd26", 26, 14, 0, 0, int'(gray(9'd24)));
    rewind = 1'b1; latch_addr = 1'b1; tick(); rewind = 1'b0; latch_addr = 1'b0;
    chk_all("rewind_latch", 24, 16, 0, 0, int'(gray(9'd24)));
    read = 1'b1; tick(); read = 1'b0;
    chk_all("held_rd25", 25, 15, 0, 0, int'(gray(9'd24)));
    rewind = 1'b1; commit = 1'b1; tick(); rewind = 1'b0; commit = 1'b0;
    chk_all("rewind_commit", 24, 16, 0, 0, int'(gray(9'd24)));
    read = 1'b1; tick(); read = 1'b0;
    chk_all("after_rc", 25, 15, 0, 0, int'(gray(9'd25)));

    // Reset while holding a snapshot.
    latch_addr = 1'b1; tick(); latch_addr = 1'b0;
    read = 1'b1; tick(2); read = 1'b0;
    chk_all("pre_reset", 27, 13, 0, 0, int'(gray(9'd25)));
    reset_n = 1'b0; tick();
    chk_all("reset_held", 0, 0, 1, 1, 0);

    // Wrap and full occupancy.
    wr_ptr = gray(9'd250); reset_n = 1'b1;
    tick(3);
    chk_all("wr250", 0, 250, 0, 0, 0);
    read = 1'b1; read_burst(0, 250); read = 1'b0;
    chk_all("rd250", 250, 0, 1, 1, int'(gray(9'd250)));
    wr_ptr = gray(9'd506);
    tick(3);
    chk_all("full", 250, 256, 0, 0, int'(gray(9'd250)));
    read = 1'b1; read_burst(250, 256); read = 1'b0;
    chk_all("rd506", 250, 0, 1, 1, int'(gray(9'd506)));
    wr_ptr = gray(9'd5);
    tick(3);
    chk_all("wrap_level", 250, 11, 0, 0, int'(gray(9'd506)));
    read = 1'b1; read_burst(506, 11); read = 1'b0;
    chk_all("wrapped", 5, 0, 1, 1, int'(gray(9'd5)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
